// File: rtl/axi_line_reader_if.sv
// Minimal AXI4 channel bundle used by axi_line_reader; the master only ever
// reads, but the write channels are carried so the bus is complete.
interface axi_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;

   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_line_reader.sv
// Reads a run of 64-byte lines over AXI, one single-beat read at a time,
// and hands them to the consumer through a small first-word-fall-through FIFO.
//
// state | meaning
// IDLE  | waiting for start_i
// ADDR  | issue AR for current line once the FIFO has a free slot
// DATA  | wait for the single R beat, push it into the FIFO
// DRAIN | all lines fetched, wait for the consumer to empty the FIFO
// DONE  | one-cycle done_o pulse
module axi_line_reader #(
   parameter int ADDR_WIDTH     = 64,
   parameter int COUNT_WIDTH    = 32,
   parameter int FIFO_LOG_DEPTH = 2
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [ADDR_WIDTH-1:0]  base_addr_i,
   input  logic [COUNT_WIDTH-1:0] num_lines_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o,
   axi_if.master                  axi_bus,
   output logic [511:0]           data_o,
   output logic                   data_valid_o,
   input  logic                   data_ready_i
);
   localparam int DEPTH = 2**FIFO_LOG_DEPTH;
   localparam logic [FIFO_LOG_DEPTH:0]   DEPTH_CNT = (FIFO_LOG_DEPTH+1)'(DEPTH);
   localparam logic [FIFO_LOG_DEPTH:0]   CNT_ONE   = (FIFO_LOG_DEPTH+1)'(1);
   localparam logic [FIFO_LOG_DEPTH-1:0] PTR_ONE   = FIFO_LOG_DEPTH'(1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [COUNT_WIDTH-1:0]    remaining_q, remaining_d;
   logic                      error_q, error_d;
   logic [FIFO_LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG_DEPTH:0]   count_q, count_d;
   logic [511:0]              mem_q [DEPTH];

   logic push, pop, fifo_empty, fifo_has_room;
   logic arvalid, rready, done;

   assign fifo_empty    = (count_q == '0);
   assign fifo_has_room = (count_q < DEPTH_CNT);
   assign pop           = !fifo_empty && data_ready_i;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      error_d     = error_q;
      push        = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      done        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d      = {base_addr_i[ADDR_WIDTH-1:6], 6'b0};
               remaining_d = num_lines_i;
               error_d     = 1'b0;
               state_d     = (num_lines_i != '0) ? ADDR : DONE;
            end
         end
         ADDR: begin
            // Occupancy only falls while here, so arvalid never drops before arready.
            arvalid = fifo_has_room;
            if (arvalid && axi_bus.arready) begin
               addr_d  = addr_q + ADDR_WIDTH'(64);
               state_d = DATA;
            end
         end
         DATA: begin
            rready = 1'b1;
            if (axi_bus.rvalid) begin
               push        = 1'b1;
               remaining_d = remaining_q - COUNT_WIDTH'(1);
               if (axi_bus.rresp != 2'b00) error_d = 1'b1;
               state_d     = (remaining_d != '0) ? ADDR : DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         error_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         error_q     <= error_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (push) mem_q[wr_ptr_q] <= axi_bus.rdata;
   end

   assign data_o       = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign data_valid_o = !fifo_empty;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done;
   assign error_o      = error_q;

   assign axi_bus.arid    = '0;
   assign axi_bus.araddr  = addr_q;
   assign axi_bus.arlen   = 8'd0;
   assign axi_bus.arsize  = 3'b110;
   assign axi_bus.arburst = 2'b01;
   assign axi_bus.arvalid = arvalid;
   assign axi_bus.rready  = rready;

   assign axi_bus.awid    = '0;
   assign axi_bus.awaddr  = '0;
   assign axi_bus.awlen   = 8'd0;
   assign axi_bus.awsize  = 3'b000;
   assign axi_bus.awburst = 2'b00;
   assign axi_bus.awvalid = 1'b0;
   assign axi_bus.wdata   = '0;
   assign axi_bus.wstrb   = '0;
   assign axi_bus.wlast   = 1'b0;
   assign axi_bus.wvalid  = 1'b0;
   assign axi_bus.bready  = 1'b1;

   logic unused_inputs;
   assign unused_inputs = ^{axi_bus.rid, axi_bus.rlast, axi_bus.awready, axi_bus.wready,
                            axi_bus.bid, axi_bus.bresp, axi_bus.bvalid, base_addr_i[5:0]};
endmodule

// File: tb/tb_axi_line_reader.sv
// Directed bench for axi_line_reader: a single-beat AXI memory model, a table of
// jobs with hand-computed addresses, and hand-written backpressure/reset sequences.
module tb_axi_line_reader;
   logic         clock_i = 1'b0;
   logic         reset_i;
   logic         start_i;
   logic [63:0]  base_addr_i;
   logic [31:0]  num_lines_i;
   logic         busy_o, done_o, error_o;
   logic [511:0] data_o;
   logic         data_valid_o;
   logic         data_ready_i;

   axi_if #(.ADDR_WIDTH(64), .DATA_WIDTH(512)) axi_bus ();

   axi_line_reader dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .num_lines_i  (num_lines_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .axi_bus      (axi_bus),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i)
   );

   always #5 clock_i = ~clock_i;

   int errors = 0;
   int checks = 0;

   int          lat      = 1;
   bit          stall_ar = 1'b0;
   logic [63:0] err_idx  = '1;

   logic [63:0]  ar_q[$];
   logic [511:0] got_q[$];
   int done_cnt = 0, busy_cycles = 0, dv_cycles = 0;
   int outstanding_viol = 0, stable_viol = 0, ar_stable_viol = 0;

   function automatic logic [511:0] line_data(input logic [63:0] idx);
      logic [511:0] d;
      for (int k = 0; k < 16; k++)
         d[k*32 +: 32] = (idx[31:0] * 32'h9E37_79B9) ^ (32'h0101_0101 * 32'(k));
      return d;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_line(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model and monitors: observe at negedge, drive #1 after posedge.
   initial begin : slave
      bit          hs_ar, hs_r, rst_s, pend, hold_prev, arv_prev;
      int          cnt, rogue;
      logic [63:0] araddr_s, pend_addr, prev_araddr;
      logic [511:0] prev_data;
      pend = 0; cnt = 0; rogue = 0; hold_prev = 0; arv_prev = 0;
      pend_addr = '0; prev_araddr = '0; prev_data = '0;
      axi_bus.arready = 1'b1; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0;
      axi_bus.rresp = 2'b00; axi_bus.rid = '0; axi_bus.rlast = 1'b1;
      axi_bus.awready = 1'b1; axi_bus.wready = 1'b1; axi_bus.bvalid = 1'b0;
      axi_bus.bresp = 2'b00; axi_bus.bid = '0;
      forever begin
         @(negedge clock_i);
         rst_s    = reset_i;
         hs_ar    = axi_bus.arvalid && axi_bus.arready;
         hs_r     = axi_bus.rvalid && axi_bus.rready;
         araddr_s = axi_bus.araddr;
         if (hs_ar && !rst_s) begin
            if (pend || axi_bus.rvalid) outstanding_viol++;
            ar_q.push_back(araddr_s);
         end
         if (data_valid_o && data_ready_i) got_q.push_back(data_o);
         if (data_valid_o) dv_cycles++;
         if (hold_prev && data_valid_o && data_o !== prev_data) stable_viol++;
         hold_prev = data_valid_o && !data_ready_i;
         prev_data = data_o;
         if (arv_prev && !rst_s && !(axi_bus.arvalid && araddr_s == prev_araddr)) ar_stable_viol++;
         arv_prev    = axi_bus.arvalid && !axi_bus.arready;
         prev_araddr = araddr_s;
         if (done_o) done_cnt++;
         if (busy_o) busy_cycles++;
         @(posedge clock_i);
         #1;
         if (rst_s) begin
            // Abandoned read: the memory still fires its beat a little later.
            if (pend || axi_bus.rvalid) rogue = 3;
            pend = 0;
            axi_bus.rvalid = 1'b0;
         end else if (rogue > 0) begin
            axi_bus.rvalid = (rogue > 1);
            axi_bus.rdata  = line_data(64'hDEAD);
            axi_bus.rresp  = 2'b00;
            rogue--;
         end else begin
            if (hs_r) axi_bus.rvalid = 1'b0;
            if (hs_ar) begin
               pend = 1; pend_addr = araddr_s; cnt = lat;
            end
            if (pend) begin
               if (cnt == 0) begin
                  axi_bus.rvalid = 1'b1;
                  axi_bus.rdata  = line_data(pend_addr >> 6);
                  axi_bus.rresp  = ((pend_addr >> 6) == err_idx) ? 2'b10 : 2'b00;
                  pend = 0;
               end else begin
                  cnt--;
               end
            end
         end
         axi_bus.arready = stall_ar ? ~axi_bus.arready : 1'b1;
      end
   end

   task automatic start_job(input logic [63:0] base, input logic [31:0] num);
      @(posedge clock_i); #1;
      base_addr_i = base; num_lines_i = num; start_i = 1'b1;
      @(posedge clock_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, input string name);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clock_i); #1;
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s: done pulses 0 after %0d cycles, expected 1", name, budget);
      end
   endtask

   typedef struct {
      logic [63:0] base;
      int          num;
      int          err_line;
      int          lat;
      bit          stall;
      logic [63:0] first;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int d0, b0, dv0;
      logic [63:0] a;
      vecs[0] = '{64'h0,                   4, -1, 1, 1'b0, 64'h0,                   1'b0};
      vecs[1] = '{64'h47,                  2, -1, 0, 1'b0, 64'h40,                  1'b0};
      vecs[2] = '{64'h1000,                3,  1, 2, 1'b0, 64'h1000,                1'b1};
      vecs[3] = '{64'h205,                 1, -1, 1, 1'b1, 64'h200,                 1'b0};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFC0, 2, -1, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0};
      vecs[5] = '{64'h3F,                  5,  4, 0, 1'b0, 64'h0,                   1'b1};

      reset_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_lines_i = '0; data_ready_i = 1'b1;
      repeat (3) @(posedge clock_i);
      #1;
      check64("rst_busy",    64'(busy_o), 64'd0);
      check64("rst_done",    64'(done_o), 64'd0);
      check64("rst_error",   64'(error_o), 64'd0);
      check64("rst_dvalid",  64'(data_valid_o), 64'd0);
      check64("rst_arvalid", 64'(axi_bus.arvalid), 64'd0);
      check64("rst_araddr",  axi_bus.araddr, 64'd0);
      check64("rst_rready",  64'(axi_bus.rready), 64'd0);
      check_line("rst_data", data_o, '0);
      reset_i = 1'b0;

      foreach (vecs[n]) begin
         lat      = vecs[n].lat;
         stall_ar = vecs[n].stall;
         err_idx  = (vecs[n].err_line >= 0) ? (vecs[n].first >> 6) + 64'(vecs[n].err_line) : '1;
         ar_q.delete(); got_q.delete();
         d0 = done_cnt;
         start_job(vecs[n].base, 32'(vecs[n].num));
         check64($sformatf("v%0d_err_clear", n), 64'(error_o), 64'd0);
         check64($sformatf("v%0d_busy", n), 64'(busy_o), 64'd1);
         wait_done(d0, 300, $sformatf("v%0d_done", n));
         check64($sformatf("v%0d_busy_after", n), 64'(busy_o), 64'd0);
         repeat (2) @(posedge clock_i);
         #1;
         check64($sformatf("v%0d_done_count", n), 64'(done_cnt - d0), 64'd1);
         check64($sformatf("v%0d_error", n), 64'(error_o), 64'(vecs[n].exp_err));
         check64($sformatf("v%0d_ar_count", n), 64'(ar_q.size()), 64'(vecs[n].num));
         check64($sformatf("v%0d_line_count", n), 64'(got_q.size()), 64'(vecs[n].num));
         for (int i = 0; i < vecs[n].num; i++) begin
            a = vecs[n].first + 64'(64 * i);
            if (i < ar_q.size())  check64($sformatf("v%0d_araddr%0d", n, i), ar_q[i], a);
            if (i < got_q.size()) check_line($sformatf("v%0d_line%0d", n, i), got_q[i], line_data(a >> 6));
         end
      end
      stall_ar = 1'b0;
      err_idx  = '1;

      // Zero-length job: DONE straight after start, no AR.
      ar_q.delete(); got_q.delete();
      d0 = done_cnt; b0 = busy_cycles;
      start_job(64'h80, 32'd0);
      check64("zero_done_next", 64'(done_o), 64'd1);
      check64("zero_busy_next", 64'(busy_o), 64'd1);
      repeat (4) @(posedge clock_i);
      #1;
      check64("zero_busy_cycles", 64'(busy_cycles - b0), 64'd1);
      check64("zero_done_count", 64'(done_cnt - d0), 64'd1);
      check64("zero_ar_count", 64'(ar_q.size()), 64'd0);

      // Backpressure: FIFO of 4 fills, AR stops, then all 8 lines flow in order.
      ar_q.delete(); got_q.delete();
      lat = 1; data_ready_i = 1'b0;
      d0 = done_cnt;
      start_job(64'h0, 32'd8);
      repeat (40) @(posedge clock_i);
      #1;
      check64("bp_ar_count_held", 64'(ar_q.size()), 64'd4);
      check64("bp_arvalid_held", 64'(axi_bus.arvalid), 64'd0);
      check64("bp_dvalid_held", 64'(data_valid_o), 64'd1);
      check_line("bp_head_line", data_o, line_data(64'd0));
      start_i = 1'b1; base_addr_i = 64'h5000; num_lines_i = 32'd1;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clock_i);
      #1;
      data_ready_i = 1'b1;
      wait_done(d0, 300, "bp_done");
      repeat (2) @(posedge clock_i);
      #1;
      check64("bp_done_count", 64'(done_cnt - d0), 64'd1);
      check64("bp_ar_count", 64'(ar_q.size()), 64'd8);
      check64("bp_line_count", 64'(got_q.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < ar_q.size())  check64($sformatf("bp_araddr%0d", i), ar_q[i], 64'(64 * i));
         if (i < got_q.size()) check_line($sformatf("bp_line%0d", i), got_q[i], line_data(64'(i)));
      end

      // Reset while waiting for an R beat; the late beat must be dropped.
      ar_q.delete(); got_q.delete();
      lat = 6;
      d0 = done_cnt;
      start_job(64'h0, 32'd4);
      for (int i = 0; i < 20 && ar_q.size() == 0; i++) begin
         @(posedge clock_i); #1;
      end
      check64("rj_first_ar", 64'(ar_q.size()), 64'd1);
      reset_i = 1'b1;
      @(posedge clock_i); #1;
      reset_i = 1'b0;
      check64("rj_busy", 64'(busy_o), 64'd0);
      check64("rj_rready", 64'(axi_bus.rready), 64'd0);
      check64("rj_araddr", axi_bus.araddr, 64'd0);
      dv0 = dv_cycles;
      repeat (8) @(posedge clock_i);
      #1;
      check64("rj_late_beat_dvalid", 64'(dv_cycles - dv0), 64'd0);
      check64("rj_no_done", 64'(done_cnt - d0), 64'd0);
      ar_q.delete(); got_q.delete();
      lat = 1;
      start_job(64'h100, 32'd1);
      wait_done(d0, 300, "rj_done");
      repeat (2) @(posedge clock_i);
      #1;
      check64("rj_done_count", 64'(done_cnt - d0), 64'd1);
      check64("rj_araddr0", (ar_q.size() > 0) ? ar_q[0] : '1, 64'h100);
      check64("rj_line_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) check_line("rj_line4", got_q[0], line_data(64'd4));

      check64("one_outstanding", 64'(outstanding_viol), 64'd0);
      check64("data_stable", 64'(stable_viol), 64'd0);
      check64("ar_stable", 64'(ar_stable_viol), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
